// File: rtl/pmem_pkg.sv
// Shared types for the physical-memory arbiter: FSM state encoding and line width default.
package pmem_pkg;

  localparam int LINE_WIDTH_DEF = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_RETRY = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first requester found searching upward from ptr, with wrap.
module rr_arbiter #(
  parameter int NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0]         req,
  input  logic [$clog2(NUM_PORTS)-1:0] ptr,
  output logic [NUM_PORTS-1:0]         grant,
  output logic [$clog2(NUM_PORTS)-1:0] grant_idx,
  output logic                         grant_any
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  always_comb begin
    int j;
    logic [IDX_W-1:0] j_idx;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    j         = 0;
    j_idx     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_PORTS) j = j - NUM_PORTS;
      j_idx = IDX_W'(j);
      if (!grant_any && req[j_idx]) begin
        grant_any    = 1'b1;
        grant[j_idx] = 1'b1;
        grant_idx    = j_idx;
      end
    end
  end

endmodule

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one physical memory port among NUM_PORTS cache ports.
// Define ARB_ERR_RETRY_EN to reissue an operation after pm_error (up to MAX_RETRY times).
//
// state | meaning
// IDLE  | sample requests, grant one port and latch its operation
// BUSY  | drive latched op to pmem until pmem_resp
// RETRY | one idle pmem cycle before reissuing after an error
// DONE  | pulse port_resp (and port_error) of the granted port
module pmem_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int LINE_WIDTH = pmem_pkg::LINE_WIDTH_DEF,
  parameter int MAX_RETRY  = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_PORTS-1:0]                 port_read,
  input  logic [NUM_PORTS-1:0]                 port_write,
  input  logic [NUM_PORTS-1:0][31:0]           port_address,
  input  logic [NUM_PORTS-1:0][LINE_WIDTH-1:0] port_wdata,
  output logic [LINE_WIDTH-1:0]                port_rdata,
  output logic [NUM_PORTS-1:0]                 port_resp,
  output logic [NUM_PORTS-1:0]                 port_error,
  output logic                                 pmem_read,
  output logic                                 pmem_write,
  output logic [31:0]                          pmem_address,
  output logic [LINE_WIDTH-1:0]                pmem_wdata,
  input  logic                                 pmem_resp,
  input  logic                                 pm_error,
  input  logic [LINE_WIDTH-1:0]                pmem_rdata
);

  import pmem_pkg::*;

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int CNT_W = $clog2(MAX_RETRY + 2);
`ifdef ARB_ERR_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif
  localparam int RETRY_LIMIT = RETRY_EN ? MAX_RETRY : 0;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     ptr, gnt_idx;
  logic [NUM_PORTS-1:0] req, gnt_oh, lat_oh;
  logic                 gnt_any;
  logic                 lat_write, lat_err;
  logic [31:0]          lat_addr;
  logic [LINE_WIDTH-1:0] lat_wdata;
  logic [CNT_W-1:0]     retry_cnt;
  logic                 retry_now;

  assign req = port_read | port_write;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
    .req       (req),
    .ptr       (ptr),
    .grant     (gnt_oh),
    .grant_idx (gnt_idx),
    .grant_any (gnt_any)
  );

  assign retry_now = pm_error && (int'(retry_cnt) < RETRY_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (gnt_any) state_nxt = ST_BUSY;
      ST_BUSY:  if (pmem_resp) state_nxt = retry_now ? ST_RETRY : ST_DONE;
      ST_RETRY: state_nxt = ST_BUSY;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= '0;
      lat_oh     <= '0;
      lat_write  <= 1'b0;
      lat_err    <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      retry_cnt  <= '0;
      port_rdata <= '0;
    end else begin
      if (state == ST_IDLE && gnt_any) begin
        lat_oh    <= gnt_oh;
        lat_write <= port_write[gnt_idx];
        lat_addr  <= port_address[gnt_idx];
        lat_wdata <= port_wdata[gnt_idx];
        lat_err   <= 1'b0;
        retry_cnt <= '0;
        ptr       <= (gnt_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
      end
      // Read data is kept only from the final attempt of a transaction.
      if (state == ST_BUSY && pmem_resp) begin
        if (retry_now) begin
          retry_cnt <= retry_cnt + 1'b1;
        end else begin
          lat_err <= pm_error;
          if (!lat_write) port_rdata <= pmem_rdata;
        end
      end
    end
  end

  assign pmem_read    = (state == ST_BUSY) && !lat_write;
  assign pmem_write   = (state == ST_BUSY) && lat_write;
  assign pmem_address = lat_addr;
  assign pmem_wdata   = lat_wdata;
  assign port_resp    = (state == ST_DONE) ? lat_oh : '0;
  assign port_error   = port_resp & {NUM_PORTS{lat_err}};

endmodule

// File: tb/tb_pmem_arbiter.sv
// Randomized bench for pmem_arbiter: bench plays requesters and memory, predicts grants and timing.
module tb_pmem_arbiter;

  localparam int N  = 4;
  localparam int LW = 64;
  localparam int MR = 3;
`ifdef ARB_ERR_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         port_read, port_write;
  logic [N-1:0][31:0]   port_address;
  logic [N-1:0][LW-1:0] port_wdata;
  logic [LW-1:0]        port_rdata;
  logic [N-1:0]         port_resp, port_error;
  logic                 pmem_read, pmem_write;
  logic [31:0]          pmem_address;
  logic [LW-1:0]        pmem_wdata;
  logic                 pmem_resp, pm_error;
  logic [LW-1:0]        pmem_rdata;

  int n_checks = 0;
  int n_pass   = 0;
  int mdl_ptr  = 0;
  logic [LW-1:0] mdl_rdata = '0;
  int op_starts = 0;
  logic prev_act = 1'b0;

  pmem_arbiter #(.NUM_PORTS(N), .LINE_WIDTH(LW), .MAX_RETRY(MR)) dut (
    .clk          (clk),
    .rst          (rst),
    .port_read    (port_read),
    .port_write   (port_write),
    .port_address (port_address),
    .port_wdata   (port_wdata),
    .port_rdata   (port_rdata),
    .port_resp    (port_resp),
    .port_error   (port_error),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_resp    (pmem_resp),
    .pm_error     (pm_error),
    .pmem_rdata   (pmem_rdata)
  );

  always #5 clk = ~clk;

  // Counts distinct memory operations (rising edges of pmem activity).
  always @(posedge clk) begin
    if ((pmem_read || pmem_write) && !prev_act) op_starts <= op_starts + 1;
    prev_act <= pmem_read || pmem_write;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [N-1:0] req);
    for (int i = 0; i < N; i++)
      if (req[(mdl_ptr + i) % N]) return (mdl_ptr + i) % N;
    return 0;
  endfunction

  task automatic new_port(input int p, input bit rd, input bit wr);
    port_read[p]    = rd;
    port_write[p]   = wr;
    port_address[p] = $urandom;
    port_wdata[p]   = {$urandom, $urandom};
  endtask

  // Called in an IDLE cycle with at least one request pending.
  task automatic run_txn(input int k, input int nerr, input logic [LW-1:0] rd);
    int g, att, starts0, exp_ops;
    logic wr;
    logic [N-1:0] oh;
    logic [97:0] exp_op;
    g       = pick(port_read | port_write);
    wr      = port_write[g];
    exp_op  = {~wr, wr, port_address[g], port_wdata[g]};
    mdl_ptr = (g + 1) % N;
    exp_ops = RETRY ? ((nerr < MR ? nerr : MR) + 1) : 1;
    starts0 = op_starts;
    oh      = '0;
    oh[g]   = 1'b1;
    att     = 0;
    tick();
    forever begin
      for (int c = 1; c <= k; c++) begin
        check("pmem_op", 128'({pmem_read, pmem_write, pmem_address, pmem_wdata}), 128'(exp_op));
        check("resp_busy", 128'(port_resp), 128'(0));
        if (c == k) begin
          pmem_resp  = 1'b1;
          pm_error   = (att < nerr);
          pmem_rdata = rd;
        end
        tick();
        pmem_resp  = 1'b0;
        pm_error   = 1'b0;
        pmem_rdata = {$urandom, $urandom};
      end
      if (RETRY && att < nerr && att < MR) begin
        check("retry_gap", 128'({port_resp, pmem_read, pmem_write}), 128'(0));
        tick();
        att++;
      end else begin
        break;
      end
    end
    if (!wr) mdl_rdata = rd;
    check("port_resp", 128'(port_resp), 128'(oh));
    check("port_error", 128'(port_error), 128'((att < nerr) ? oh : '0));
    check("pmem_released", 128'({pmem_read, pmem_write}), 128'(0));
    check("port_rdata", 128'(port_rdata), 128'(mdl_rdata));
    check("op_count", 128'(op_starts - starts0), 128'(exp_ops));
    tick();
    check("resp_one_pulse", 128'({port_resp, port_error}), 128'(0));
    port_read[g]  = 1'b0;
    port_write[g] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] add;
    rst          = 1'b1;
    port_read    = '0;
    port_write   = '0;
    port_address = '0;
    port_wdata   = '0;
    pmem_resp    = 1'b0;
    pm_error     = 1'b0;
    pmem_rdata   = '0;
    tick();
    tick();
    check("reset_pmem", 128'({pmem_read, pmem_write, pmem_address}), 128'(0));
    check("reset_wdata", 128'(pmem_wdata), 128'(0));
    check("reset_resp", 128'({port_resp, port_error}), 128'(0));
    check("reset_rdata", 128'(port_rdata), 128'(0));
    rst = 1'b0;
    tick();

    // Single read on port 0, response on the third pmem cycle.
    new_port(0, 1'b1, 1'b0);
    run_txn(3, 0, {8{8'hA5}});

    // Ports 0 and 1 requesting continuously alternate.
    for (int i = 0; i < 4; i++) begin
      if (!port_read[0]) new_port(0, 1'b1, 1'b0);
      if (!port_read[1]) new_port(1, 1'b1, 1'b0);
      run_txn(2, 0, {$urandom, $urandom});
    end
    port_read = '0;

    // Move pointer to 3, then requests on 1 and 2: wrap grants 1 then 2.
    new_port(2, 1'b1, 1'b0);
    run_txn(1, 0, {$urandom, $urandom});
    new_port(1, 1'b1, 1'b0);
    new_port(2, 1'b0, 1'b1);
    run_txn(2, 0, {$urandom, $urandom});
    run_txn(2, 0, {$urandom, $urandom});

    // Read and write together on port 1 behaves as a write.
    new_port(1, 1'b1, 1'b1);
    port_address[1] = 32'h0000_1000;
    run_txn(2, 0, {$urandom, $urandom});

    // Reset in the middle of BUSY.
    new_port(2, 1'b1, 1'b0);
    tick();
    check("pre_rst_busy", 128'(pmem_read), 128'(1));
    rst = 1'b1;
    #1;
    check("rst_async_pmem", 128'({pmem_read, pmem_write, pmem_address}), 128'(0));
    check("rst_async_resp", 128'({port_resp, port_error}), 128'(0));
    check("rst_async_rdata", 128'(port_rdata), 128'(0));
    port_read = '0;
    mdl_ptr   = 0;
    mdl_rdata = '0;
    tick();
    rst = 1'b0;
    tick();
    check("rst_no_resp", 128'({port_resp, pmem_read, pmem_write}), 128'(0));
    new_port(0, 1'b1, 1'b0);
    new_port(2, 1'b0, 1'b1);
    run_txn(2, 0, {$urandom, $urandom});
    run_txn(2, 0, {$urandom, $urandom});

    // Errors on the first two responses.
    new_port(3, 1'b1, 1'b0);
    run_txn(2, 2, {$urandom, $urandom});
    new_port(1, 1'b0, 1'b1);
    run_txn(1, 5, {$urandom, $urandom});

    // Random traffic.
    for (int t = 0; t < 40; t++) begin
      add = N'($urandom_range(0, (1 << N) - 1)) & ~(port_read | port_write);
      if ((add | port_read | port_write) == '0) add[$urandom_range(0, N - 1)] = 1'b1;
      for (int p = 0; p < N; p++) begin
        if (add[p]) begin
          case ($urandom_range(0, 2))
            0:       new_port(p, 1'b1, 1'b0);
            1:       new_port(p, 1'b0, 1'b1);
            default: new_port(p, 1'b1, 1'b1);
          endcase
        end
      end
      run_txn($urandom_range(1, 4),
              ($urandom_range(0, 9) < 2) ? $urandom_range(1, 4) : 0,
              {$urandom, $urandom});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
